// File: rtl/sum_accumulator_if.sv
// Handshake bundle for sum_accumulator: beat input, block-total output
// and the synchronous clear control.
interface sum_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              overflow;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, overflow
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, overflow
  );
endinterface

// File: rtl/sum_accumulator.sv
// Sums N_SAMPLES adder beats into a block total with a sticky carry flag,
// then holds the total on a valid/ready port until taken.
module sum_accumulator #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int N_SAMPLES = 4
) (
  input logic            clk,
  input logic            rst,
  sum_accumulator_if.slave bus
);
  localparam int CNT_W =
    (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_SAMPLES - 1);

  typedef enum logic {
    ACCUM,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n;
  logic [ACC_W-1:0] res, res_n;
  logic             rovf, rovf_n;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             take;

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = res;
  assign bus.overflow  = rovf;

  assign accept = bus.in_valid & bus.in_ready;
  assign take   = bus.out_valid & bus.out_ready;
  assign sum    = {1'b0, acc}
                + (ACC_W+1)'(bus.in_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      res   <= '0;
      rovf  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
      res   <= res_n;
      rovf  <= rovf_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    res_n   = res;
    rovf_n  = rovf;
    if (bus.clear) begin
      // result register is left alone on abort
      state_n = ACCUM;
      acc_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept && cnt == LAST) begin
            res_n   = sum[ACC_W-1:0];
            rovf_n  = ovf | sum[ACC_W];
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
            state_n = DONE;
          end else if (accept) begin
            acc_n = sum[ACC_W-1:0];
            cnt_n = cnt + CNT_W'(1);
            ovf_n = ovf | sum[ACC_W];
          end
        end
        DONE: begin
          if (take) state_n = ACCUM;
        end
        default: state_n = ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench: default, 8-bit-accumulator and single-sample
// configurations of sum_accumulator.
module tb_sum_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sum_accumulator_if #(.DATA_W(8), .ACC_W(16)) ifa ();
  sum_accumulator_if #(.DATA_W(8), .ACC_W(8))  ifb ();
  sum_accumulator_if #(.DATA_W(8), .ACC_W(16)) ifc ();

  sum_accumulator #(.DATA_W(8), .ACC_W(16), .N_SAMPLES(4))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  sum_accumulator #(.DATA_W(8), .ACC_W(8), .N_SAMPLES(4))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  sum_accumulator #(.DATA_W(8), .ACC_W(16), .N_SAMPLES(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  task automatic check(input string tag,
                       input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int u, input logic v,
                        input logic [7:0] d);
    case (u)
      0: begin ifa.in_valid = v; ifa.in_data = d; end
      1: begin ifb.in_valid = v; ifb.in_data = d; end
      default: begin ifc.in_valid = v; ifc.in_data = d; end
    endcase
  endtask

  task automatic feed(input int u, input logic [7:0] d);
    set_in(u, 1'b1, d);
    step();
    set_in(u, 1'b0, 8'd0);
  endtask

  int results;
  int bubbles;

  initial begin
    ifa.clear = 0; ifa.in_valid = 0; ifa.in_data = 0;
    ifa.out_ready = 1;
    ifb.clear = 0; ifb.in_valid = 0; ifb.in_data = 0;
    ifb.out_ready = 1;
    ifc.clear = 0; ifc.in_valid = 0; ifc.in_data = 0;
    ifc.out_ready = 1;
    rst = 1;
    step(); step();
    rst = 0;
    check("rst_valid", 32'(ifa.out_valid), 0);
    check("rst_ready", 32'(ifa.in_ready), 1);
    check("rst_data", 32'(ifa.out_data), 0);
    check("rst_ovf", 32'(ifa.overflow), 0);

    // 1: basic block
    feed(0, 10); feed(0, 20); feed(0, 30);
    check("t1_pre_valid", 32'(ifa.out_valid), 0);
    feed(0, 40);
    check("t1_valid", 32'(ifa.out_valid), 1);
    check("t1_data", 32'(ifa.out_data), 100);
    check("t1_ovf", 32'(ifa.overflow), 0);
    check("t1_inrdy", 32'(ifa.in_ready), 0);
    step();
    check("t1_taken", 32'(ifa.out_valid), 0);
    check("t1_rdy_back", 32'(ifa.in_ready), 1);

    // 2: backpressure
    ifa.out_ready = 0;
    feed(0, 1); feed(0, 2); feed(0, 3); feed(0, 4);
    set_in(0, 1'b1, 8'd99);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(ifa.out_valid), 1);
      check("t2_hold_data", 32'(ifa.out_data), 10);
      check("t2_hold_rdy", 32'(ifa.in_ready), 0);
      step();
    end
    set_in(0, 1'b0, 8'd0);
    ifa.out_ready = 1;
    step();
    check("t2_release", 32'(ifa.out_valid), 0);
    feed(0, 5); feed(0, 5); feed(0, 5); feed(0, 5);
    check("t2_next_data", 32'(ifa.out_data), 20);
    step();

    // 4: clear mid-block, beat in clear cycle discarded
    feed(0, 50); feed(0, 60);
    ifa.clear = 1;
    set_in(0, 1'b1, 8'd70);
    step();
    ifa.clear = 0;
    set_in(0, 1'b0, 8'd0);
    check("t4_clr_valid", 32'(ifa.out_valid), 0);
    check("t4_clr_keep", 32'(ifa.out_data), 20);
    ifa.out_ready = 0;
    feed(0, 1); feed(0, 2); feed(0, 3);
    check("t4_pre_valid", 32'(ifa.out_valid), 0);
    feed(0, 4);
    check("t4_valid", 32'(ifa.out_valid), 1);
    check("t4_data", 32'(ifa.out_data), 10);
    // clear while a result is pending
    ifa.clear = 1;
    step();
    ifa.clear = 0;
    check("t4_done_clr", 32'(ifa.out_valid), 0);
    check("t4_done_keep", 32'(ifa.out_data), 10);
    ifa.out_ready = 1;

    // 5: streaming
    results = 0;
    bubbles = 0;
    set_in(0, 1'b1, 8'd5);
    for (int i = 0; i < 12; i++) begin
      step();
      if (ifa.out_valid) begin
        results++;
        check("t5_data", 32'(ifa.out_data), 20);
      end
      if (!ifa.in_ready) bubbles++;
    end
    set_in(0, 1'b0, 8'd0);
    check("t5_results", results, 2);
    check("t5_bubbles", bubbles, 2);
    ifa.clear = 1;
    step();
    ifa.clear = 0;

    // 6: reset mid-block
    feed(0, 7); feed(0, 7);
    rst = 1;
    step();
    rst = 0;
    check("t6_data", 32'(ifa.out_data), 0);
    check("t6_valid", 32'(ifa.out_valid), 0);
    check("t6_rdy", 32'(ifa.in_ready), 1);
    check("t6_ovf", 32'(ifa.overflow), 0);
    feed(0, 1); feed(0, 1); feed(0, 1); feed(0, 1);
    check("t6_after_valid", 32'(ifa.out_valid), 1);
    check("t6_after_data", 32'(ifa.out_data), 4);
    step();

    // 3: overflow with 8-bit accumulator
    feed(1, 255); feed(1, 255); feed(1, 1); feed(1, 1);
    check("t3_valid", 32'(ifb.out_valid), 1);
    check("t3_data", 32'(ifb.out_data), 0);
    check("t3_ovf", 32'(ifb.overflow), 1);
    step();
    feed(1, 1); feed(1, 1); feed(1, 1); feed(1, 1);
    check("t3_next_data", 32'(ifb.out_data), 4);
    check("t3_next_ovf", 32'(ifb.overflow), 0);
    step();

    // single-sample blocks
    feed(2, 9);
    check("n1_valid", 32'(ifc.out_valid), 1);
    check("n1_data", 32'(ifc.out_data), 9);
    step();
    check("n1_taken", 32'(ifc.out_valid), 0);
    feed(2, 200);
    check("n1_data2", 32'(ifc.out_data), 200);
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
